// File: rtl/gpio_pad_pkg.sv
// rtl/gpio_pad_pkg.sv - register offsets and shared types for the GPIO pad bank
package gpio_pad_pkg;

  localparam int GPIO_MAX_PADS = 32;

  localparam logic [7:0] GPIO_OUT     = 8'h00;
  localparam logic [7:0] GPIO_OE      = 8'h04;
  localparam logic [7:0] GPIO_IE      = 8'h08;
  localparam logic [7:0] GPIO_PU      = 8'h0C;
  localparam logic [7:0] GPIO_PD      = 8'h10;
  localparam logic [7:0] GPIO_CS      = 8'h14;
  localparam logic [7:0] GPIO_SL      = 8'h18;
  localparam logic [7:0] GPIO_ALT     = 8'h1C;
  localparam logic [7:0] GPIO_IN      = 8'h20;
  localparam logic [7:0] GPIO_RISE_EN = 8'h24;
  localparam logic [7:0] GPIO_FALL_EN = 8'h28;
  localparam logic [7:0] GPIO_STATUS  = 8'h2C;

  typedef enum logic [7:0] {
    GPIO_REG_OUT     = GPIO_OUT,
    GPIO_REG_OE      = GPIO_OE,
    GPIO_REG_IE      = GPIO_IE,
    GPIO_REG_PU      = GPIO_PU,
    GPIO_REG_PD      = GPIO_PD,
    GPIO_REG_CS      = GPIO_CS,
    GPIO_REG_SL      = GPIO_SL,
    GPIO_REG_ALT     = GPIO_ALT,
    GPIO_REG_IN      = GPIO_IN,
    GPIO_REG_RISE_EN = GPIO_RISE_EN,
    GPIO_REG_FALL_EN = GPIO_FALL_EN,
    GPIO_REG_STATUS  = GPIO_STATUS
  } gpio_reg_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - single-bit input synchroniser with rise/fall edge detect
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/gpio_pad_bank.sv
// rtl/gpio_pad_bank.sv - register-controlled bidirectional pad bank with edge interrupts
module gpio_pad_bank
  import gpio_pad_pkg::*;
#(
  parameter int NUM_PADS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bus_valid,
  input  logic                bus_we,
  input  logic [ADDR_W-1:0]   bus_addr,
  input  logic [31:0]         bus_wdata,
  output logic [31:0]         bus_rdata,
  output logic                bus_ready,
  input  logic [NUM_PADS-1:0] alt_out,
  input  logic [NUM_PADS-1:0] alt_oe,
  output logic [NUM_PADS-1:0] alt_in,
  input  logic [NUM_PADS-1:0] pad_in,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] pad_oe,
  output logic [NUM_PADS-1:0] pad_cs,
  output logic [NUM_PADS-1:0] pad_sl,
  output logic [NUM_PADS-1:0] pad_ie,
  output logic [NUM_PADS-1:0] pad_pu,
  output logic [NUM_PADS-1:0] pad_pd,
  output logic                irq
);

  logic [NUM_PADS-1:0] out_q, oe_q, ie_q, pu_q, pd_q, cs_q, sl_q, alt_q;
  logic [NUM_PADS-1:0] rise_en_q, fall_en_q, status_q;
  logic [NUM_PADS-1:0] sync_v, rise_v, fall_v;
  logic [NUM_PADS-1:0] wdata_n, status_set, status_clr;
  logic [31:0]         addr_full, rdata_n;
  logic                access, wr, addr_in_map;
  gpio_reg_e           reg_sel;
  logic                unused_bits;

  assign access      = bus_valid & ~bus_ready;
  assign wr          = access & bus_we;
  assign addr_full   = 32'(bus_addr) & 32'hFFFF_FFFC;
  assign addr_in_map = (addr_full >> 8) == 32'h0;
  assign reg_sel     = gpio_reg_e'(addr_full[7:0]);
  assign wdata_n     = bus_wdata[NUM_PADS-1:0];
  assign unused_bits = ^bus_wdata;

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (pad_in[i]),
      .sync (sync_v[i]),
      .rise (rise_v[i]),
      .fall (fall_v[i])
    );
  end

  always_comb begin
    rdata_n = 32'h0;
    if (addr_in_map) begin
      case (reg_sel)
        GPIO_REG_OUT:     rdata_n = 32'(out_q);
        GPIO_REG_OE:      rdata_n = 32'(oe_q);
        GPIO_REG_IE:      rdata_n = 32'(ie_q);
        GPIO_REG_PU:      rdata_n = 32'(pu_q);
        GPIO_REG_PD:      rdata_n = 32'(pd_q);
        GPIO_REG_CS:      rdata_n = 32'(cs_q);
        GPIO_REG_SL:      rdata_n = 32'(sl_q);
        GPIO_REG_ALT:     rdata_n = 32'(alt_q);
        GPIO_REG_IN:      rdata_n = 32'(sync_v);
        GPIO_REG_RISE_EN: rdata_n = 32'(rise_en_q);
        GPIO_REG_FALL_EN: rdata_n = 32'(fall_en_q);
        GPIO_REG_STATUS:  rdata_n = 32'(status_q);
        default:          rdata_n = 32'h0;
      endcase
    end
  end

  // New edges are OR-ed in after the clear so a coincident set survives.
  assign status_set = (rise_v & rise_en_q) | (fall_v & fall_en_q);
  assign status_clr = (wr && addr_in_map && reg_sel == GPIO_REG_STATUS) ? wdata_n : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      oe_q      <= '0;
      ie_q      <= '1;
      pu_q      <= '0;
      pd_q      <= '0;
      cs_q      <= '0;
      sl_q      <= '0;
      alt_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      bus_ready <= 1'b0;
      bus_rdata <= 32'h0;
      irq       <= 1'b0;
    end else begin
      if (wr && addr_in_map) begin
        case (reg_sel)
          GPIO_REG_OUT:     out_q     <= wdata_n;
          GPIO_REG_OE:      oe_q      <= wdata_n;
          GPIO_REG_IE:      ie_q      <= wdata_n;
          GPIO_REG_PU:      pu_q      <= wdata_n;
          GPIO_REG_PD:      pd_q      <= wdata_n;
          GPIO_REG_CS:      cs_q      <= wdata_n;
          GPIO_REG_SL:      sl_q      <= wdata_n;
          GPIO_REG_ALT:     alt_q     <= wdata_n;
          GPIO_REG_RISE_EN: rise_en_q <= wdata_n;
          GPIO_REG_FALL_EN: fall_en_q <= wdata_n;
          default:          ;
        endcase
      end
      status_q  <= (status_q & ~status_clr) | status_set;
      bus_ready <= access;
      bus_rdata <= access ? rdata_n : 32'h0;
      irq       <= |status_q;
    end
  end

  assign alt_in  = sync_v;
  assign pad_out = (alt_q & alt_out) | (~alt_q & out_q);
  assign pad_oe  = (alt_q & alt_oe) | (~alt_q & oe_q);
  assign pad_cs  = cs_q;
  assign pad_sl  = sl_q;
  assign pad_ie  = ie_q;
  assign pad_pu  = pu_q;
  assign pad_pd  = pd_q & ~pu_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// tb/tb_gpio_pad_bank.sv - directed self-checking bench for gpio_pad_bank
module tb_gpio_pad_bank;

  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_valid, bus_we;
  logic [5:0]    bus_addr;
  logic [31:0]   bus_wdata, bus_rdata;
  logic          bus_ready;
  logic [NP-1:0] alt_out, alt_oe, alt_in, pad_in;
  logic [NP-1:0] pad_out, pad_oe, pad_cs, pad_sl, pad_ie, pad_pu, pad_pd;
  logic          irq;
  logic [31:0]   rd_data;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  gpio_pad_bank #(.NUM_PADS(NP), .SYNC_STAGES(2), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .alt_out   (alt_out),
    .alt_oe    (alt_oe),
    .alt_in    (alt_in),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .pad_cs    (pad_cs),
    .pad_sl    (pad_sl),
    .pad_ie    (pad_ie),
    .pad_pu    (pad_pu),
    .pad_pd    (pad_pd),
    .irq       (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_access(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    int k;
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus_ready && k < 8);
    check_eq("bus_ready_pulse", 32'(bus_ready), 32'h1);
    rdata     = bus_rdata;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    bus_access(1'b1, addr, data, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_access(1'b0, addr, 32'h0, d);
    check_eq(tag, d, exp);
  endtask

  initial begin
    logic [31:0] reset_exp [12];
    reset_exp = '{32'h0, 32'h0, 32'h0000_FFFF, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    rst = 1'b1; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    alt_out = '0; alt_oe = '0; pad_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset values
    check_eq("idle_ready", 32'(bus_ready), 32'h0);
    check_eq("idle_rdata", bus_rdata, 32'h0);
    check_eq("rst_pad_ie", 32'(pad_ie), 32'h0000_FFFF);
    check_eq("rst_irq", 32'(irq), 32'h0);
    for (int i = 0; i < 12; i++)
      rd_check($sformatf("rst_reg_%02h", i * 4), 6'(i * 4), reset_exp[i]);

    // write / readback
    wr(6'h00, 32'h0000_A5A5);
    check_eq("pad_out_wr", 32'(pad_out), 32'h0000_A5A5);
    wr(6'h04, 32'h0000_00FF);
    check_eq("pad_oe_wr", 32'(pad_oe), 32'h0000_00FF);
    rd_check("rd_out", 6'h00, 32'h0000_A5A5);
    tick();
    check_eq("ready_one_cycle", 32'(bus_ready), 32'h0);
    check_eq("rdata_zero_idle", bus_rdata, 32'h0);
    wr(6'h04, 32'hFFFF_FFFF);
    rd_check("rd_oe_masked", 6'h04, 32'h0000_FFFF);
    wr(6'h07, 32'h0000_1234);
    rd_check("addr_low_bits_ignored", 6'h04, 32'h0000_1234);

    // alternate function mux
    wr(6'h04, 32'h0);
    wr(6'h00, 32'h0000_A5A4);
    alt_out = 16'h0001; alt_oe = 16'h0001;
    wr(6'h1C, 32'h0000_0001);
    check_eq("alt_pad_out", 32'(pad_out), 32'h0000_A5A5);
    check_eq("alt_pad_oe", 32'(pad_oe), 32'h0000_0001);
    wr(6'h1C, 32'h0);
    check_eq("noalt_pad_out", 32'(pad_out), 32'h0000_A5A4);
    check_eq("noalt_pad_oe", 32'(pad_oe), 32'h0);

    // synchroniser latency
    pad_in[3] = 1'b1;
    tick();
    check_eq("sync_lat_1", 32'(alt_in), 32'h0);
    tick();
    check_eq("sync_lat_2", 32'(alt_in), 32'h0000_0008);
    rd_check("rd_in", 6'h20, 32'h0000_0008);
    rd_check("no_status_unenabled", 6'h2C, 32'h0);

    // one-cycle glitch on pad 5 with falling-edge enable
    wr(6'h28, 32'h0000_0020);
    pad_in[5] = 1'b1;
    tick();
    check_eq("glitch_e1", 32'(alt_in[5]), 32'h0);
    pad_in[5] = 1'b0;
    tick();
    check_eq("glitch_e2", 32'(alt_in[5]), 32'h1);
    tick();
    check_eq("glitch_e3", 32'(alt_in[5]), 32'h0);
    tick();
    check_eq("glitch_irq_lag", 32'(irq), 32'h0);
    tick();
    check_eq("glitch_irq", 32'(irq), 32'h1);
    rd_check("glitch_status", 6'h2C, 32'h0000_0020);
    wr(6'h2C, 32'h0000_0020);
    rd_check("glitch_cleared", 6'h2C, 32'h0);
    check_eq("glitch_irq_clr", 32'(irq), 32'h0);

    // rising-edge interrupt and W1C race
    wr(6'h24, 32'h0000_0008);
    pad_in[3] = 1'b0;
    repeat (4) tick();
    pad_in[3] = 1'b1;
    tick();
    tick();
    tick();
    check_eq("rise_irq_lag", 32'(irq), 32'h0);
    tick();
    check_eq("rise_irq", 32'(irq), 32'h1);
    rd_check("rise_status", 6'h2C, 32'h0000_0008);
    pad_in[3] = 1'b0;
    repeat (4) tick();
    pad_in[3] = 1'b1;
    tick();
    tick();
    wr(6'h2C, 32'h0000_0008);
    rd_check("race_set_wins", 6'h2C, 32'h0000_0008);
    check_eq("race_irq", 32'(irq), 32'h1);
    wr(6'h24, 32'h0);
    rd_check("en_clear_keeps_status", 6'h2C, 32'h0000_0008);
    wr(6'h2C, 32'h0000_0008);
    rd_check("late_clear", 6'h2C, 32'h0);
    check_eq("late_clear_irq", 32'(irq), 32'h0);

    // pad controls, pull conflict, unmapped and read-only
    wr(6'h0C, 32'h0000_0001);
    wr(6'h10, 32'h0000_0003);
    check_eq("pu_win_pu", 32'(pad_pu), 32'h0000_0001);
    check_eq("pu_win_pd", 32'(pad_pd), 32'h0000_0002);
    rd_check("rd_pd", 6'h10, 32'h0000_0003);
    wr(6'h14, 32'h0000_00F0);
    wr(6'h18, 32'h0000_0F00);
    check_eq("pad_cs", 32'(pad_cs), 32'h0000_00F0);
    check_eq("pad_sl", 32'(pad_sl), 32'h0000_0F00);
    wr(6'h08, 32'h0000_00FF);
    check_eq("pad_ie", 32'(pad_ie), 32'h0000_00FF);
    wr(6'h30, 32'hFFFF_FFFF);
    rd_check("unmapped", 6'h30, 32'h0);
    wr(6'h20, 32'h0);
    rd_check("in_readonly", 6'h20, 32'h0000_0008);

    // reset during a sampled write
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 6'h00; bus_wdata = 32'h0000_1234;
    rst = 1'b1;
    tick();
    check_eq("rst_mid_ready", 32'(bus_ready), 32'h0);
    bus_valid = 1'b0; bus_we = 1'b0;
    rst = 1'b0;
    tick();
    check_eq("rst_mid_ready2", 32'(bus_ready), 32'h0);
    check_eq("rst_mid_pad_out", 32'(pad_out), 32'h0);
    check_eq("rst_mid_pad_pu", 32'(pad_pu), 32'h0);
    check_eq("rst_mid_pad_ie", 32'(pad_ie), 32'h0000_FFFF);
    check_eq("rst_mid_irq", 32'(irq), 32'h0);
    rd_check("rst_mid_out", 6'h00, 32'h0);
    rd_check("rst_mid_cs", 6'h14, 32'h0);
    rd_check("rst_mid_fall_en", 6'h28, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
